// File: rtl/mod_pkg.sv
// mod_pkg: shared widths, FSM encoding and counter width
// for the mod_reduce_32 restoring shift-subtract reducer.
package mod_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int MOD_W_DEF = 16;
  localparam int CNT_W     = $clog2(IN_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_sub_step.sv
// mod_sub_step: one restoring compare-subtract step,
// returns r - modulus when r >= modulus, else r.
module mod_sub_step #(
  parameter int MOD_W = 16
) (
  input  logic [MOD_W:0]   r,
  input  logic [MOD_W-1:0] modulus,
  output logic [MOD_W:0]   r_next
);

  logic [MOD_W:0] m_ext;

  assign m_ext  = {1'b0, modulus};
  assign r_next = (r >= m_ext) ? (r - m_ext) : r;

endmodule

// File: rtl/mod_reduce_32.sv
// mod_reduce_32: serial unsigned dividend mod modulus, one bit/cycle.
// Optional macro MOD_REDUCE_EARLY_EXIT_EN: dividend < modulus exits early.
module mod_reduce_32
  import mod_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int MOD_W = MOD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MOD_W-1:0] modulus,
  input  logic [IN_W-1:0]  input_tdata,
  input  logic             input_tvalid,
  output logic             input_tready,
  output logic [MOD_W-1:0] output_tdata,
  output logic             output_tvalid,
  input  logic             output_tready,
  output logic             output_err,
  output logic             busy
);

  localparam int CW =
    (IN_W == IN_W_DEF) ? CNT_W : $clog2(IN_W);

  state_t           state;
  state_t           state_nx;
  logic [IN_W-1:0]  div_q;
  logic [MOD_W-1:0] mod_q;
  logic [MOD_W:0]   r_q;
  logic [MOD_W:0]   r_shift;
  logic [MOD_W:0]   r_nx;
  logic [CW-1:0]    cnt_q;
  logic [MOD_W-1:0] out_q;
  logic             err_q;
  logic             rdy_q;
  logic             accept;
  logic             first;
  logic             last;
  logic             zero_mod;
  logic             early;

  // r stays below modulus, so its top bit is always free to shift into
  assign r_shift = {r_q[MOD_W-1:0], div_q[IN_W-1]};

  mod_sub_step #(
    .MOD_W (MOD_W)
  ) u_step (
    .r       (r_shift),
    .modulus (mod_q),
    .r_next  (r_nx)
  );

  assign accept   = input_tvalid & input_tready;
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == CW'(IN_W - 1));
  assign zero_mod = (mod_q == '0);

`ifdef MOD_REDUCE_EARLY_EXIT_EN
  assign early = (div_q < IN_W'(mod_q)) & ~zero_mod;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = RUN;
        end
      end
      RUN: begin
        if ((first && (zero_mod || early)) || last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (output_tready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      mod_q <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            div_q <= input_tdata;
            mod_q <= modulus;
            r_q   <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        RUN: begin
          if (first && zero_mod) begin
            out_q <= '1;
            err_q <= 1'b1;
          end else if (first && early) begin
            out_q <= div_q[MOD_W-1:0];
          end else begin
            r_q   <= r_nx;
            div_q <= div_q << 1;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              out_q <= r_nx[MOD_W-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ready waits one edge after reset release
  assign input_tready  = rdy_q & (state == IDLE);
  assign output_tvalid = (state == DONE);
  assign output_tdata  = out_q;
  assign output_err    = err_q;
  assign busy          = (state != IDLE);

endmodule
